// File: rtl/sap_microseq_ctrl.sv
// Microprogrammed control sequencer for the SAP datapath: two fixed fetch microsteps,
// then execute microwords read from a writable table indexed by {opcode, exec step}.
module sap_microseq_ctrl #(
    parameter int                  OPCODE_W = 4,
    parameter int                  CTRL_W   = 17,
    parameter int                  STEP_W   = 3,
    parameter logic [CTRL_W-1:0]   FETCH0   = 17'h00048,
    parameter logic [CTRL_W-1:0]   FETCH1   = 17'h00112,
    parameter logic [OPCODE_W-1:0] HLT_OP   = 4'hC
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [OPCODE_W-1:0]        opcode,
    input  logic [1:0]                 flags,
    input  logic                       step_mode,
    input  logic                       step_go,
    input  logic                       ucode_we,
    input  logic [OPCODE_W+STEP_W-1:0] ucode_addr,
    input  logic [CTRL_W+2:0]          ucode_wdata,
    output logic [CTRL_W-1:0]          ctrl_word,
    output logic [STEP_W:0]            tstate,
    output logic                       halted,
    output logic                       instr_done
);

    localparam int DEPTH = 2 ** (OPCODE_W + STEP_W);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT,
        S_FETCH0,
        S_FETCH1,
        S_EXEC,
        S_HALT
    } state_t;

    state_t              state_q, state_d;
    logic [STEP_W-1:0]   step_q, step_d;
    logic [OPCODE_W-1:0] op_q, op_d;
    logic [CTRL_W-1:0]   ctrl_q, ctrl_d;
    logic [STEP_W:0]     tstate_q, tstate_d;
    logic                halted_q, halted_d;
    logic                end_q, end_d;
    logic [1:0]          cond_q, cond_d;

    logic [CTRL_W+2:0]   ucode_q [DEPTH];
    logic [CTRL_W+2:0]   rd_word;
    logic                cond_ok;
    logic                last_step;

    // The table has no reset so a loaded microprogram survives rst.
    always_ff @(negedge clk) begin
        if (ucode_we) begin
            ucode_q[ucode_addr] <= ucode_wdata;
        end
    end

    always_ff @(negedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            step_q   <= '0;
            op_q     <= '0;
            ctrl_q   <= '0;
            tstate_q <= '0;
            halted_q <= 1'b0;
            end_q    <= 1'b0;
            cond_q   <= '0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            op_q     <= op_d;
            ctrl_q   <= ctrl_d;
            tstate_q <= tstate_d;
            halted_q <= halted_d;
            end_q    <= end_d;
            cond_q   <= cond_d;
        end
    end

    // END/COND of the active word are held in registers; only the flags are live.
    always_comb begin
        case (cond_q)
            2'b01:   cond_ok = flags[1];
            2'b10:   cond_ok = flags[0];
            default: cond_ok = 1'b1;
        endcase
    end

    assign last_step = end_q | ~cond_ok | (step_q == {STEP_W{1'b1}});

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        op_d    = op_q;
        case (state_q)
            S_IDLE:   state_d = step_mode ? S_WAIT : S_FETCH0;
            S_WAIT:   if (step_go) state_d = S_FETCH0;
            S_FETCH0: state_d = S_FETCH1;
            S_FETCH1: begin
                op_d    = opcode;
                step_d  = '0;
                state_d = (opcode == HLT_OP) ? S_HALT : S_EXEC;
            end
            S_EXEC: begin
                if (last_step) begin
                    state_d = step_mode ? S_WAIT : S_FETCH0;
                end else begin
                    step_d = step_q + STEP_W'(1);
                end
            end
            S_HALT:   state_d = S_HALT;
            default:  state_d = S_IDLE;
        endcase
    end

    // Reading the word of the step being entered keeps table latency at zero extra cycles.
    assign rd_word = ucode_q[{op_d, step_d}];

    always_comb begin
        ctrl_d   = '0;
        tstate_d = '0;
        halted_d = 1'b0;
        end_d    = 1'b0;
        cond_d   = '0;
        case (state_d)
            S_FETCH0: ctrl_d = FETCH0;
            S_FETCH1: begin
                ctrl_d   = FETCH1;
                tstate_d = (STEP_W + 1)'(1);
            end
            S_EXEC: begin
                ctrl_d   = rd_word[CTRL_W-1:0];
                end_d    = rd_word[CTRL_W+2];
                cond_d   = rd_word[CTRL_W+1:CTRL_W];
                tstate_d = {1'b0, step_d} + (STEP_W + 1)'(2);
            end
            S_HALT:   halted_d = 1'b1;
            default:  ctrl_d = '0;
        endcase
    end

    assign ctrl_word  = ctrl_q;
    assign tstate     = tstate_q;
    assign halted     = halted_q;
    assign instr_done = ((state_q == S_FETCH1) && (opcode == HLT_OP)) ||
                        ((state_q == S_EXEC) && last_step);

endmodule

// File: tb/tb_sap_microseq_ctrl.sv
// Self-checking bench for sap_microseq_ctrl: vector table plus hand-written corner sequences,
// with expected outputs queued when inputs are driven and checked once the DUT has settled.
module tb_sap_microseq_ctrl;

    typedef struct {
        logic        rst;
        logic [3:0]  opcode;
        logic [1:0]  flags;
        logic        stepMode;
        logic        stepGo;
        logic        we;
        logic [6:0]  addr;
        logic [19:0] wdata;
        logic [16:0] expCtrl;
        logic [3:0]  expT;
        logic        expHalt;
        logic        expDone;
    } vec_t;

    typedef struct {
        logic [16:0] ctrl;
        logic [3:0]  t;
        logic        h;
        logic        d;
        int          id;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  opcode;
    logic [1:0]  flags;
    logic        stepMode;
    logic        stepGo;
    logic        ucodeWe;
    logic [6:0]  ucodeAddr;
    logic [19:0] ucodeWdata;
    logic [16:0] ctrlWord;
    logic [3:0]  tstate;
    logic        halted;
    logic        instrDone;

    int   checks = 0;
    int   errors = 0;
    int   vecId  = 0;
    exp_t sb[$];
    vec_t tbl[$];

    always #5 clk = ~clk;

    sap_microseq_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .flags       (flags),
        .step_mode   (stepMode),
        .step_go     (stepGo),
        .ucode_we    (ucodeWe),
        .ucode_addr  (ucodeAddr),
        .ucode_wdata (ucodeWdata),
        .ctrl_word   (ctrlWord),
        .tstate      (tstate),
        .halted      (halted),
        .instr_done  (instrDone)
    );

    function automatic logic [19:0] uw(input logic e, input logic [1:0] c, input logic [16:0] w);
        return {e, c, w};
    endfunction

    function automatic vec_t mk(input logic r, input logic [3:0] op, input logic [1:0] fl,
                                input logic sm, input logic go, input logic [16:0] c,
                                input logic [3:0] t, input logic h, input logic d);
        vec_t v;
        v.rst = r;       v.opcode = op;  v.flags = fl;   v.stepMode = sm; v.stepGo = go;
        v.we = 1'b0;     v.addr = '0;    v.wdata = '0;
        v.expCtrl = c;   v.expT = t;     v.expHalt = h;  v.expDone = d;
        return v;
    endfunction

    function automatic vec_t wr(input vec_t vIn, input logic [6:0] a, input logic [19:0] w);
        vec_t v = vIn;
        v.we = 1'b1; v.addr = a; v.wdata = w;
        return v;
    endfunction

    task automatic cmp(input string nm, input int id, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s vec %0d: got 0x%0h, expected 0x%0h", nm, id, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v);
        exp_t e;
        rst = v.rst; opcode = v.opcode; flags = v.flags; stepMode = v.stepMode; stepGo = v.stepGo;
        ucodeWe = v.we; ucodeAddr = v.addr; ucodeWdata = v.wdata;
        e.ctrl = v.expCtrl; e.t = v.expT; e.h = v.expHalt; e.d = v.expDone; e.id = vecId;
        sb.push_back(e);
        vecId++;
    endtask

    task automatic checkOutput();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL scoreboard: got empty queue, expected an entry");
        end else begin
            e = sb.pop_front();
            cmp("ctrl_word",  e.id, 32'(ctrlWord),  32'(e.ctrl));
            cmp("tstate",     e.id, 32'(tstate),    32'(e.t));
            cmp("halted",     e.id, 32'(halted),    32'(e.h));
            cmp("instr_done", e.id, 32'(instrDone), 32'(e.d));
        end
    endtask

    // Inputs change just after the rising edge so they are stable for the next falling edge.
    task automatic runVec(input vec_t v);
        @(posedge clk);
        #1;
        applyStimulus(v);
        #1;
        checkOutput();
    endtask

    initial begin
        rst = 1'b1; opcode = '0; flags = '0; stepMode = 1'b0; stepGo = 1'b0;
        ucodeWe = 1'b0; ucodeAddr = '0; ucodeWdata = '0;
        repeat (2) @(negedge clk);

        tbl.push_back(wr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), {4'h0, 3'd0}, uw(0, 2'b00, 17'h000C0)));
        tbl.push_back(wr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), {4'h0, 3'd1}, uw(1, 2'b00, 17'h01002)));
        tbl.push_back(wr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), {4'h6, 3'd0}, uw(0, 2'b01, 17'h10000)));
        tbl.push_back(wr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), {4'h6, 3'd1}, uw(1, 2'b00, 17'h00084)));
        tbl.push_back(wr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), {4'h3, 3'd0}, uw(0, 2'b10, 17'h00200)));
        tbl.push_back(wr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), {4'h3, 3'd1}, uw(1, 2'b00, 17'h00400)));
        tbl.push_back(wr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), {4'h4, 3'd0}, uw(0, 2'b11, 17'h00011)));
        tbl.push_back(wr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), {4'h4, 3'd1}, uw(1, 2'b00, 17'h00022)));
        tbl.push_back(wr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), {4'h2, 3'd0}, uw(1, 2'b00, 17'h00000)));
        for (int s = 0; s < 8; s++) begin
            tbl.push_back(wr(mk(1, 0, 0, 0, 0, 0, 0, 0, 0), {4'h5, 3'(s)}, uw(0, 2'b00, 17'(17'h00100 + s))));
        end
        tbl.push_back(mk(1, 0, 0, 0, 0, 17'h00000, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 17'h00000, 0, 0, 0));
        // LDA
        tbl.push_back(mk(0, 0, 0, 0, 0, 17'h00048, 0, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 17'h00112, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 17'h000C0, 2, 0, 0));
        tbl.push_back(mk(0, 0, 0, 0, 0, 17'h01002, 3, 0, 1));
        // JMPZ not taken, then taken
        tbl.push_back(mk(0, 6, 0, 0, 0, 17'h00048, 0, 0, 0));
        tbl.push_back(mk(0, 6, 0, 0, 0, 17'h00112, 1, 0, 0));
        tbl.push_back(mk(0, 6, 2'b00, 0, 0, 17'h10000, 2, 0, 1));
        tbl.push_back(mk(0, 6, 0, 0, 0, 17'h00048, 0, 0, 0));
        tbl.push_back(mk(0, 6, 0, 0, 0, 17'h00112, 1, 0, 0));
        tbl.push_back(mk(0, 6, 2'b10, 0, 0, 17'h10000, 2, 0, 0));
        tbl.push_back(mk(0, 6, 2'b10, 0, 0, 17'h00084, 3, 0, 1));
        // carry-conditional, taken then not taken with Z set
        tbl.push_back(mk(0, 3, 0, 0, 0, 17'h00048, 0, 0, 0));
        tbl.push_back(mk(0, 3, 0, 0, 0, 17'h00112, 1, 0, 0));
        tbl.push_back(mk(0, 3, 2'b01, 0, 0, 17'h00200, 2, 0, 0));
        tbl.push_back(mk(0, 3, 2'b01, 0, 0, 17'h00400, 3, 0, 1));
        tbl.push_back(mk(0, 3, 2'b10, 0, 0, 17'h00048, 0, 0, 0));
        tbl.push_back(mk(0, 3, 2'b10, 0, 0, 17'h00112, 1, 0, 0));
        tbl.push_back(mk(0, 3, 2'b10, 0, 0, 17'h00200, 2, 0, 1));
        // COND=11 behaves as unconditional
        tbl.push_back(mk(0, 4, 0, 0, 0, 17'h00048, 0, 0, 0));
        tbl.push_back(mk(0, 4, 0, 0, 0, 17'h00112, 1, 0, 0));
        tbl.push_back(mk(0, 4, 0, 0, 0, 17'h00011, 2, 0, 0));
        tbl.push_back(mk(0, 4, 0, 0, 0, 17'h00022, 3, 0, 1));
        // NOP
        tbl.push_back(mk(0, 2, 0, 0, 0, 17'h00048, 0, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0, 17'h00112, 1, 0, 0));
        tbl.push_back(mk(0, 2, 0, 0, 0, 17'h00000, 2, 0, 1));

        for (int i = 0; i < tbl.size(); i++) begin
            runVec(tbl[i]);
        end

        // HALT holds through 20 cycles and still accepts a table write
        runVec(mk(0, 4'hC, 0, 0, 0, 17'h00048, 0, 0, 0));
        runVec(mk(0, 4'hC, 0, 0, 0, 17'h00112, 1, 0, 1));
        for (int i = 0; i < 20; i++) begin
            if (i == 5) runVec(wr(mk(0, 4'hC, 0, 0, 0, 17'h0, 0, 1, 0), {4'h7, 3'd0}, uw(1, 2'b00, 17'h1ABCD)));
            else        runVec(mk(0, 4'hC, 0, 0, 0, 17'h0, 0, 1, 0));
        end
        runVec(mk(1, 7, 0, 0, 0, 17'h00000, 0, 1, 0));
        runVec(mk(0, 7, 0, 0, 0, 17'h00000, 0, 0, 0));
        runVec(mk(0, 7, 0, 0, 0, 17'h00048, 0, 0, 0));
        runVec(mk(0, 7, 0, 0, 0, 17'h00112, 1, 0, 0));
        runVec(mk(0, 7, 0, 1, 0, 17'h1ABCD, 2, 0, 1));

        // step mode: WAIT holds, one go pulse releases one instruction
        for (int i = 0; i < 3; i++) runVec(mk(0, 0, 0, 1, 0, 17'h0, 0, 0, 0));
        runVec(mk(0, 0, 0, 1, 1, 17'h00000, 0, 0, 0));
        runVec(mk(0, 0, 0, 1, 0, 17'h00048, 0, 0, 0));
        runVec(mk(0, 0, 0, 1, 0, 17'h00112, 1, 0, 0));
        runVec(mk(0, 0, 0, 1, 0, 17'h000C0, 2, 0, 0));
        runVec(mk(0, 0, 0, 1, 0, 17'h01002, 3, 0, 1));
        for (int i = 0; i < 3; i++) runVec(mk(0, 0, 0, 1, 0, 17'h0, 0, 0, 0));

        // eight non-ending words force an end at tstate 9; then rst mid-instruction
        runVec(mk(0, 5, 0, 1, 1, 17'h00000, 0, 0, 0));
        runVec(mk(0, 5, 0, 0, 0, 17'h00048, 0, 0, 0));
        runVec(mk(0, 5, 0, 0, 0, 17'h00112, 1, 0, 0));
        for (int s = 0; s < 8; s++) begin
            runVec(mk(0, 5, 0, 0, 0, 17'(17'h00100 + s), 4'(2 + s), 0, (s == 7)));
        end
        runVec(mk(0, 5, 0, 0, 0, 17'h00048, 0, 0, 0));
        runVec(mk(0, 5, 0, 0, 0, 17'h00112, 1, 0, 0));
        runVec(mk(0, 5, 0, 0, 0, 17'h00100, 2, 0, 0));
        runVec(mk(0, 5, 0, 0, 0, 17'h00101, 3, 0, 0));
        runVec(mk(1, 5, 0, 0, 0, 17'h00102, 4, 0, 0));
        runVec(mk(0, 0, 0, 1, 0, 17'h00000, 0, 0, 0));
        runVec(mk(0, 0, 0, 1, 0, 17'h00000, 0, 0, 0));

        // table writes during an active LDA: old word this time, new word next time
        runVec(mk(0, 0, 0, 1, 1, 17'h00000, 0, 0, 0));
        runVec(mk(0, 0, 0, 0, 0, 17'h00048, 0, 0, 0));
        runVec(mk(0, 0, 0, 0, 0, 17'h00112, 1, 0, 0));
        runVec(wr(mk(0, 0, 0, 0, 0, 17'h000C0, 2, 0, 0), {4'h0, 3'd0}, uw(0, 2'b00, 17'h0F0F0)));
        runVec(mk(0, 0, 0, 0, 0, 17'h01002, 3, 0, 1));
        runVec(mk(0, 0, 0, 0, 0, 17'h00048, 0, 0, 0));
        runVec(wr(mk(0, 0, 0, 0, 0, 17'h00112, 1, 0, 0), {4'h0, 3'd0}, uw(0, 2'b00, 17'h0AAAA)));
        runVec(mk(0, 0, 0, 0, 0, 17'h0F0F0, 2, 0, 0));
        runVec(mk(0, 0, 0, 0, 0, 17'h01002, 3, 0, 1));
        runVec(mk(0, 0, 0, 0, 0, 17'h00048, 0, 0, 0));
        runVec(mk(0, 0, 0, 0, 0, 17'h00112, 1, 0, 0));
        runVec(mk(0, 0, 0, 0, 0, 17'h0AAAA, 2, 0, 0));
        runVec(mk(0, 0, 0, 0, 0, 17'h01002, 3, 0, 1));
        runVec(mk(0, 0, 0, 0, 0, 17'h00048, 0, 0, 0));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
